// File: rtl/multicycle_cu_if.sv
// Control/status bundle between the multi-cycle RV32I control unit and its datapath + memory port.
// The master side is the control unit; the slave side is the datapath (or a bench standing in for it).
interface multicycle_cu_if #(
    parameter int ALUCTRL_W = 4
);
    logic [31:0]          instr;
    logic                 zero;
    logic                 lt;
    logic                 ltu;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 mem_we;
    logic                 addr_src;
    logic                 ir_write;
    logic                 pc_write;
    logic [1:0]           pc_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [2:0]           imm_src;
    logic [1:0]           result_src;
    logic                 reg_write;
    logic                 illegal;
    logic                 bus_err;

    modport master (
        input  instr, zero, lt, ltu, mem_ready,
        output mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_control, imm_src, result_src,
               reg_write, illegal, bus_err
    );

    modport slave (
        output instr, zero, lt, ltu, mem_ready,
        input  mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_control, imm_src, result_src,
               reg_write, illegal, bus_err
    );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a single
// shared memory port with a ready handshake, a bus timeout and sticky illegal/bus-error flags.
module multicycle_cu #(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    multicycle_cu_if.master cu
);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(9);

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        st_fetch, st_decode, st_exec_r, st_exec_i, st_addr, st_mem_rd, st_mem_wr,
        st_wb_alu, st_wb_mem, st_branch, st_jal, st_jalr, st_jalr_pc, st_lui, st_auipc, st_trap
    } state_t;

    state_t               st;
    state_t               nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 illegal_q;
    logic                 bus_err_q;
    logic                 set_ill;
    logic                 set_berr;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [ALUCTRL_W:0]   r_dec;
    logic [ALUCTRL_W:0]   i_dec;
    logic                 br_taken;
    logic                 mem_state;
    logic                 timeout;
    logic                 unused_instr;

    assign opcode       = cu.instr[6:0];
    assign funct3       = cu.instr[14:12];
    assign funct7       = cu.instr[31:25];
    assign unused_instr = ^{cu.instr[24:15], cu.instr[11:7]};

    // Returns {legal, op}; illegal encodings fall back to add so the ALU select stays defined.
    function automatic logic [ALUCTRL_W:0] alu_decode(input logic [2:0] f3,
                                                      input logic [6:0] f7,
                                                      input logic       is_r);
        logic                 ok;
        logic [ALUCTRL_W-1:0] op;
        ok = 1'b1;
        op = ALU_ADD;
        case (f3)
            3'b000: begin
                if (is_r && f7 == 7'b0100000) op = ALU_SUB;
                else if (is_r && f7 != 7'b0000000) ok = 1'b0;
            end
            3'b001: begin op = ALU_SLL;  ok = (f7 == 7'b0000000); end
            3'b010: begin op = ALU_SLT;  ok = !is_r || (f7 == 7'b0000000); end
            3'b011: begin op = ALU_SLTU; ok = !is_r || (f7 == 7'b0000000); end
            3'b100: begin op = ALU_XOR;  ok = !is_r || (f7 == 7'b0000000); end
            3'b101: begin
                if (f7 == 7'b0100000) op = ALU_SRA;
                else if (f7 == 7'b0000000) op = ALU_SRL;
                else ok = 1'b0;
            end
            3'b110: begin op = ALU_OR;   ok = !is_r || (f7 == 7'b0000000); end
            default: begin op = ALU_AND; ok = !is_r || (f7 == 7'b0000000); end
        endcase
        if (!ok) op = ALU_ADD;
        return {ok, op};
    endfunction

    assign r_dec     = alu_decode(funct3, funct7, 1'b1);
    assign i_dec     = alu_decode(funct3, funct7, 1'b0);
    assign mem_state = (st == st_fetch) || (st == st_mem_rd) || (st == st_mem_wr);
    assign timeout   = (cnt == CNT_LIMIT);

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = cu.zero;
            3'b001:  br_taken = !cu.zero;
            3'b100:  br_taken = cu.lt;
            3'b101:  br_taken = !cu.lt;
            3'b110:  br_taken = cu.ltu;
            3'b111:  br_taken = !cu.ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // The wait counter only advances while a memory state is stalled; any state change clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= st_fetch;
            cnt       <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            st <= nxt;
            if (nxt == st && mem_state && !cu.mem_ready) cnt <= cnt + CNT_W'(1);
            else cnt <= '0;
            if (set_ill)  illegal_q <= 1'b1;
            if (set_berr) bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        nxt      = st;
        set_ill  = 1'b0;
        set_berr = 1'b0;
        case (st)
            st_fetch: begin
                if (cu.mem_ready) nxt = st_decode;
                else if (timeout) begin nxt = st_trap; set_berr = 1'b1; end
            end
            st_decode: begin
                case (opcode)
                    OP_R:              nxt = st_exec_r;
                    OP_I:              nxt = st_exec_i;
                    OP_LOAD, OP_STORE: nxt = st_addr;
                    OP_BRANCH:         nxt = st_branch;
                    OP_JAL:            nxt = st_jal;
                    OP_JALR:           nxt = st_jalr;
                    OP_LUI:            nxt = st_lui;
                    OP_AUIPC:          nxt = st_auipc;
                    default: begin nxt = st_trap; set_ill = 1'b1; end
                endcase
            end
            st_exec_r: begin
                if (r_dec[ALUCTRL_W]) nxt = st_wb_alu;
                else begin nxt = st_trap; set_ill = 1'b1; end
            end
            st_exec_i: begin
                if (i_dec[ALUCTRL_W]) nxt = st_wb_alu;
                else begin nxt = st_trap; set_ill = 1'b1; end
            end
            st_addr:   nxt = (opcode == OP_STORE) ? st_mem_wr : st_mem_rd;
            st_mem_rd: begin
                if (cu.mem_ready) nxt = st_wb_mem;
                else if (timeout) begin nxt = st_trap; set_berr = 1'b1; end
            end
            st_mem_wr: begin
                if (cu.mem_ready) nxt = st_fetch;
                else if (timeout) begin nxt = st_trap; set_berr = 1'b1; end
            end
            st_wb_alu, st_wb_mem, st_jal, st_jalr_pc: nxt = st_fetch;
            st_branch: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin nxt = st_trap; set_ill = 1'b1; end
                else nxt = st_fetch;
            end
            st_jalr:            nxt = st_jalr_pc;
            st_lui, st_auipc:   nxt = st_wb_alu;
            default:            nxt = st_trap;
        endcase
    end

    // Everything drops while rst_n is low so an in-flight memory request is withdrawn at once.
    always_comb begin
        cu.mem_req     = 1'b0;
        cu.mem_we      = 1'b0;
        cu.addr_src    = 1'b0;
        cu.ir_write    = 1'b0;
        cu.pc_write    = 1'b0;
        cu.pc_src      = 2'd0;
        cu.alu_src_a   = 2'd0;
        cu.alu_src_b   = 2'd0;
        cu.alu_control = ALU_ADD;
        cu.imm_src     = IMM_I;
        cu.result_src  = 2'd0;
        cu.reg_write   = 1'b0;
        if (rst_n) begin
            case (st)
                st_fetch: begin
                    cu.mem_req   = 1'b1;
                    cu.alu_src_b = 2'd2;
                    cu.ir_write  = cu.mem_ready;
                    cu.pc_write  = cu.mem_ready;
                end
                st_decode: begin
                    cu.alu_src_a = 2'd1;
                    cu.alu_src_b = 2'd1;
                    cu.imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                end
                st_exec_r: begin
                    cu.alu_src_a   = 2'd2;
                    cu.alu_control = r_dec[ALUCTRL_W-1:0];
                end
                st_exec_i: begin
                    cu.alu_src_a   = 2'd2;
                    cu.alu_src_b   = 2'd1;
                    cu.alu_control = i_dec[ALUCTRL_W-1:0];
                end
                st_addr: begin
                    cu.alu_src_a = 2'd2;
                    cu.alu_src_b = 2'd1;
                    cu.imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                st_mem_rd: begin
                    cu.mem_req  = 1'b1;
                    cu.addr_src = 1'b1;
                end
                st_mem_wr: begin
                    cu.mem_req  = 1'b1;
                    cu.mem_we   = 1'b1;
                    cu.addr_src = 1'b1;
                end
                st_wb_alu: cu.reg_write = 1'b1;
                st_wb_mem: begin
                    cu.reg_write  = 1'b1;
                    cu.result_src = 2'd1;
                end
                st_branch: begin
                    cu.alu_src_a   = 2'd2;
                    cu.alu_control = ALU_SUB;
                    cu.pc_write    = br_taken;
                    cu.pc_src      = br_taken ? 2'd1 : 2'd0;
                end
                st_jal: begin
                    cu.imm_src    = IMM_J;
                    cu.alu_src_a  = 2'd1;
                    cu.alu_src_b  = 2'd2;
                    cu.reg_write  = 1'b1;
                    cu.result_src = 2'd2;
                    cu.pc_write   = 1'b1;
                    cu.pc_src     = 2'd1;
                end
                st_jalr: begin
                    cu.alu_src_a  = 2'd1;
                    cu.alu_src_b  = 2'd2;
                    cu.reg_write  = 1'b1;
                    cu.result_src = 2'd2;
                end
                st_jalr_pc: begin
                    cu.alu_src_a = 2'd2;
                    cu.alu_src_b = 2'd1;
                    cu.pc_write  = 1'b1;
                    cu.pc_src    = 2'd2;
                end
                st_lui: begin
                    cu.alu_src_a = 2'd3;
                    cu.alu_src_b = 2'd1;
                    cu.imm_src   = IMM_U;
                end
                st_auipc: begin
                    cu.alu_src_a = 2'd1;
                    cu.alu_src_b = 2'd1;
                    cu.imm_src   = IMM_U;
                end
                default: ;
            endcase
        end
    end

    assign cu.illegal = illegal_q;
    assign cu.bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: per-cycle expected control vectors are queued as stimulus is driven and
// compared against the DUT outputs on the falling edge of the same cycle.
module tb_multicycle_cu;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] alu;
        logic [2:0] imm;
        logic [1:0] res;
        logic       reg_write;
        logic       illegal;
        logic       bus_err;
    } ctl_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    ctl_t  exp_q[$];
    string tag_q[$];
    ctl_t  mon_e;
    string mon_t;

    multicycle_cu_if #(.ALUCTRL_W(4)) bus ();

    multicycle_cu #(.ALUCTRL_W(4), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cu    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t c;
        c.mem_req   = bus.mem_req;
        c.mem_we    = bus.mem_we;
        c.addr_src  = bus.addr_src;
        c.ir_write  = bus.ir_write;
        c.pc_write  = bus.pc_write;
        c.pc_src    = bus.pc_src;
        c.src_a     = bus.alu_src_a;
        c.src_b     = bus.alu_src_b;
        c.alu       = bus.alu_control;
        c.imm       = bus.imm_src;
        c.res       = bus.result_src;
        c.reg_write = bus.reg_write;
        c.illegal   = bus.illegal;
        c.bus_err   = bus.bus_err;
        return c;
    endfunction

    // Expected vectors per state, written straight from the control table.
    function automatic ctl_t mk(input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
                                input logic [2:0] imm);
        ctl_t c = '0;
        c.src_a = a; c.src_b = b; c.alu = alu; c.imm = imm;
        return c;
    endfunction
    function automatic ctl_t e_fetch(input logic rdy);
        ctl_t c = mk(2'd0, 2'd2, 4'd0, 3'd0);
        c.mem_req = 1'b1; c.ir_write = rdy; c.pc_write = rdy;
        return c;
    endfunction
    function automatic ctl_t e_dec(input logic [2:0] imm); return mk(2'd1, 2'd1, 4'd0, imm); endfunction
    function automatic ctl_t e_wb(input logic [1:0] res);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.res = res;
        return c;
    endfunction
    function automatic ctl_t e_mem(input logic we);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.addr_src = 1'b1; c.mem_we = we;
        return c;
    endfunction
    function automatic ctl_t e_br(input logic taken);
        ctl_t c = mk(2'd2, 2'd0, 4'd1, 3'd0);
        c.pc_write = taken; c.pc_src = taken ? 2'd1 : 2'd0;
        return c;
    endfunction
    function automatic ctl_t e_trap(input logic ill, input logic berr);
        ctl_t c = '0;
        c.illegal = ill; c.bus_err = berr;
        return c;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            chk(mon_t, {9'd0, obs()}, {9'd0, mon_e});
        end
    end

    task automatic step(input string tag, input logic rdy, input ctl_t e);
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Plain ALU instructions: {instr, expected alu op, is R-type}
    logic [31:0] alu_ins [7] = '{32'h00500093, 32'h002081B3, 32'h402081B3, 32'h4020D1B3,
                                 32'h0020F1B3, 32'h4030D093, 32'h0050A093};
    logic [3:0]  alu_exp [7] = '{4'd0, 4'd0, 4'd1, 4'd9, 4'd2, 4'd9, 4'd5};
    logic        alu_isr [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        ctl_t e;
        bus.instr = 32'h0; bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0; bus.mem_ready = 1'b0;
        #1;
        chk("reset_outputs", {9'd0, obs()}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bus.instr = alu_ins[i];
            step("alu_fetch", 1'b1, e_fetch(1'b1));
            step("alu_decode", 1'b1, e_dec(3'd2));
            step("alu_exec", 1'b1, mk(2'd2, alu_isr[i] ? 2'd0 : 2'd1, alu_exp[i], 3'd0));
            step("alu_wb", 1'b1, e_wb(2'd0));
        end

        bus.instr = 32'hFE009EE3;
        for (int z = 0; z < 2; z++) begin
            bus.zero = z[0];
            step("bne_fetch", 1'b1, e_fetch(1'b1));
            step("bne_decode", 1'b1, e_dec(3'd2));
            step("bne_branch", 1'b1, e_br(!z[0]));
        end
        bus.zero = 1'b0;

        bus.instr = 32'h0020C463;
        for (int l = 0; l < 2; l++) begin
            bus.lt = l[0];
            step("blt_fetch", 1'b1, e_fetch(1'b1));
            step("blt_decode", 1'b1, e_dec(3'd2));
            step("blt_branch", 1'b1, e_br(l[0]));
        end
        bus.lt = 1'b0;

        bus.instr = 32'h0000A103;
        step("lw_fetch", 1'b1, e_fetch(1'b1));
        step("lw_decode", 1'b1, e_dec(3'd2));
        step("lw_addr", 1'b1, mk(2'd2, 2'd1, 4'd0, 3'd0));
        for (int w = 0; w < 3; w++) step("lw_memrd_wait", 1'b0, e_mem(1'b0));
        step("lw_memrd_ready", 1'b1, e_mem(1'b0));
        step("lw_wbmem", 1'b1, e_wb(2'd1));

        bus.instr = 32'h0020A223;
        step("sw_fetch_wait", 1'b0, e_fetch(1'b0));
        step("sw_fetch_wait", 1'b0, e_fetch(1'b0));
        step("sw_fetch", 1'b1, e_fetch(1'b1));
        step("sw_decode", 1'b1, e_dec(3'd2));
        step("sw_addr", 1'b1, mk(2'd2, 2'd1, 4'd0, 3'd1));
        step("sw_memwr", 1'b1, e_mem(1'b1));
        step("sw_back_fetch", 1'b0, e_fetch(1'b0));
        step("sw_back_fetch_rdy", 1'b1, e_fetch(1'b1));

        bus.instr = 32'h008000EF;
        step("jal_decode", 1'b1, e_dec(3'd4));
        e = mk(2'd1, 2'd2, 4'd0, 3'd4);
        e.reg_write = 1'b1; e.res = 2'd2; e.pc_write = 1'b1; e.pc_src = 2'd1;
        step("jal_exec", 1'b1, e);

        bus.instr = 32'h000080E7;
        step("jalr_fetch", 1'b1, e_fetch(1'b1));
        step("jalr_decode", 1'b1, e_dec(3'd2));
        e = mk(2'd1, 2'd2, 4'd0, 3'd0);
        e.reg_write = 1'b1; e.res = 2'd2;
        step("jalr_link", 1'b1, e);
        e = mk(2'd2, 2'd1, 4'd0, 3'd0);
        e.pc_write = 1'b1; e.pc_src = 2'd2;
        step("jalr_target", 1'b1, e);

        bus.instr = 32'h123450B7;
        step("lui_fetch", 1'b1, e_fetch(1'b1));
        step("lui_decode", 1'b1, e_dec(3'd2));
        step("lui_exec", 1'b1, mk(2'd3, 2'd1, 4'd0, 3'd3));
        step("lui_wb", 1'b1, e_wb(2'd0));
        bus.instr = 32'h00001097;
        step("auipc_fetch", 1'b1, e_fetch(1'b1));
        step("auipc_decode", 1'b1, e_dec(3'd2));
        step("auipc_exec", 1'b1, mk(2'd1, 2'd1, 4'd0, 3'd3));
        step("auipc_wb", 1'b1, e_wb(2'd0));

        // Ready arriving on the last allowed wait cycle must not raise a bus error.
        bus.instr = 32'h0000A103;
        step("lim_fetch", 1'b1, e_fetch(1'b1));
        step("lim_decode", 1'b1, e_dec(3'd2));
        step("lim_addr", 1'b1, mk(2'd2, 2'd1, 4'd0, 3'd0));
        for (int w = 0; w < 15; w++) step("lim_memrd_wait", 1'b0, e_mem(1'b0));
        step("lim_memrd_ready", 1'b1, e_mem(1'b0));
        step("lim_wbmem", 1'b1, e_wb(2'd1));
        step("lim_fetch_after", 1'b0, e_fetch(1'b0));

        bus.instr = 32'h402091B3;
        do_reset();
        step("rsv_fetch", 1'b1, e_fetch(1'b1));
        step("rsv_decode", 1'b1, e_dec(3'd2));
        step("rsv_exec", 1'b1, mk(2'd2, 2'd0, 4'd0, 3'd0));
        for (int t = 0; t < 3; t++) step("rsv_trap", 1'b1, e_trap(1'b1, 1'b0));

        bus.instr = 32'h00000000;
        do_reset();
        step("zero_fetch", 1'b1, e_fetch(1'b1));
        step("zero_decode", 1'b1, e_dec(3'd2));
        for (int t = 0; t < 3; t++) step("zero_trap", 1'b1, e_trap(1'b1, 1'b0));
        do_reset();
        bus.instr = 32'h00500093;
        step("post_rst_fetch", 1'b1, e_fetch(1'b1));
        step("post_rst_decode", 1'b1, e_dec(3'd2));

        bus.instr = 32'h0020A463;
        do_reset();
        step("br010_fetch", 1'b1, e_fetch(1'b1));
        step("br010_decode", 1'b1, e_dec(3'd2));
        step("br010_branch", 1'b1, e_br(1'b0));
        step("br010_trap", 1'b1, e_trap(1'b1, 1'b0));

        do_reset();
        for (int w = 0; w < 16; w++) step("to_fetch_wait", 1'b0, e_fetch(1'b0));
        step("to_trap", 1'b0, e_trap(1'b0, 1'b1));
        step("to_trap_hold", 1'b1, e_trap(1'b0, 1'b1));

        do_reset();
        bus.mem_ready = 1'b0;
        #2;
        chk("async_pre_memreq", {31'd0, bus.mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_memreq", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
